// File: rtl/clarvi_part_sequencer.sv
// -----------------------------------------------------------------------------
// clarvi_part_sequencer
//
// Steps a byte-serial ALU through the eight byte parts of one instruction.
// An accepted instruction runs for exactly eight non-held cycles (step 0..7).
// The byte index for each step depends on the latched part order. A new
// instruction may be accepted on step 7, so back-to-back instructions run
// with no bubble cycles between them.
//
// Optional feature: define CLARVI_SEQ_PERF_CNT_EN to build a free-running
// count of RUN cycles on busy_cycles. When it is not defined, busy_cycles is
// tied to zero and no counter register exists.
//
// Ports
//   clock        in   rising-edge clock for all state
//   reset        in   synchronous, active-low reset
//   in_valid     in   new instruction offered
//   in_ready     out  offered instruction is accepted this cycle
//   in_order     in   part order: 00 asc, 01 desc, 10 rshift32, 11 as asc
//   in_is32      in   instruction is a 32-bit (W) op
//   hold         in   downstream stall, freezes sequencing
//   flush        in   abort the in-flight instruction
//   part         out  byte part index for the ALU
//   is32         out  latched in_is32 of the in-flight instruction
//   alu_stall    out  ALU state-update inhibit
//   first        out  current cycle is step 0
//   last         out  current cycle is step 7
//   done         out  one-cycle pulse after an instruction completes
//   busy_cycles  out  RUN-cycle count (zero unless the perf macro is set)
// -----------------------------------------------------------------------------
module clarvi_part_sequencer #(
    parameter int PERF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_order,
    input  logic              in_is32,
    input  logic              hold,
    input  logic              flush,
    output logic [2:0]        part,
    output logic              is32,
    output logic              alu_stall,
    output logic              first,
    output logic              last,
    output logic              done,
    output logic [PERF_W-1:0] busy_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] step_reg,  step_next;
    logic [1:0] order_reg, order_next;
    logic       is32_reg,  is32_next;
    logic       done_reg,  done_next;
    logic       accept;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            order_reg <= 2'b00;
            is32_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            order_reg <= order_next;
            is32_reg  <= is32_next;
            done_reg  <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Ready is forced low during reset and flush so neither can race an
        // accept into the state register.
        in_ready = reset && !flush &&
                   ((state_reg == IDLE) ||
                    ((state_reg == RUN) && (step_reg == 3'd7) && !hold));
        accept   = in_valid && in_ready;

        state_next = state_reg;
        step_next  = step_reg;
        order_next = order_reg;
        is32_next  = is32_reg;
        done_next  = 1'b0;

        if (flush) begin
            // Flush wins over hold and accept, and never produces done.
            state_next = IDLE;
            step_next  = 3'd0;
        end else if (accept) begin
            state_next = RUN;
            step_next  = 3'd0;
            order_next = in_order;
            is32_next  = in_is32;
            // Accepting in RUN only happens on an unheld step 7, which is
            // also the completion of the previous instruction.
            done_next  = (state_reg == RUN);
        end else if ((state_reg == RUN) && !hold) begin
            if (step_reg == 3'd7) begin
                state_next = IDLE;
                step_next  = 3'd0;
                done_next  = 1'b1;
            end else begin
                step_next  = step_reg + 3'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Part index: descending is the bitwise complement of the step, and
    // rshift32 complements only the low two bits (3,2,1,0,7,6,5,4).
    // -------------------------------------------------------------------------
    always_comb begin
        part = 3'd0;
        if (state_reg == RUN) begin
            case (order_reg)
                2'b01:   part = ~step_reg;
                2'b10:   part = {step_reg[2], ~step_reg[1:0]};
                default: part = step_reg;
            endcase
        end
    end

    assign is32      = is32_reg;
    assign done      = done_reg;
    assign alu_stall = (state_reg == IDLE) || hold;
    assign first     = (state_reg == RUN) && (step_reg == 3'd0);
    assign last      = (state_reg == RUN) && (step_reg == 3'd7);

    // -------------------------------------------------------------------------
    // Optional RUN-cycle counter; counts held cycles too and survives flush.
    // -------------------------------------------------------------------------
`ifdef CLARVI_SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] busy_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_reg <= '0;
        end else if (state_reg == RUN) begin
            busy_reg <= busy_reg + PERF_W'(1);
        end
    end

    assign busy_cycles = busy_reg;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
module tb_clarvi_part_sequencer;

`ifdef CLARVI_SEQ_PERF_CNT_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_order;
    logic        in_is32;
    logic        hold;
    logic        flush;
    logic [2:0]  part;
    logic        is32;
    logic        alu_stall;
    logic        first;
    logic        last;
    logic        done;
    logic [31:0] busy_cycles;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [2:0]  exp_q[$];

    clarvi_part_sequencer #(.PERF_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_order    (in_order),
        .in_is32     (in_is32),
        .hold        (hold),
        .flush       (flush),
        .part        (part),
        .is32        (is32),
        .alu_stall   (alu_stall),
        .first       (first),
        .last        (last),
        .done        (done),
        .busy_cycles (busy_cycles)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2:0] exp_part(input logic [1:0] o, input int s);
        case (o)
            2'b01:   return 3'(7 - s);
            2'b10:   return (s < 4) ? 3'(3 - s) : 3'(11 - s);
            default: return 3'(s);
        endcase
    endfunction

    // One instruction from IDLE, optionally held for hold_len cycles at step hold_at.
    task automatic run_instr(input logic [1:0] order, input logic is32v,
                             input int hold_at, input int hold_len, input string tag);
        int run_cnt;
        int held;
        int cur_step;
        logic [2:0] e;
        in_valid = 1'b1; in_order = order; in_is32 = is32v; hold = 1'b0; flush = 1'b0;
        #1;
        chk({tag, "_accept_ready"}, in_ready, 1);
        for (int s = 0; s < 8; s++) exp_q.push_back(exp_part(order, s));
        cyc();
        in_valid = 1'b0; in_order = 2'b00; in_is32 = 1'b0;
        run_cnt = 0; held = 0;
        while (exp_q.size() > 0 && run_cnt < 40) begin
            cur_step = 8 - exp_q.size();
            hold = (cur_step == hold_at) && (held < hold_len);
            #1;
            if (hold) begin
                chk({tag, "_held_part"}, part, exp_q[0]);
                chk({tag, "_held_stall"}, alu_stall, 1);
                held++;
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_part"}, part, e);
                chk({tag, "_first"}, first, cur_step == 0);
                chk({tag, "_last"}, last, cur_step == 7);
                chk({tag, "_stall"}, alu_stall, 0);
                chk({tag, "_is32"}, is32, is32v);
            end
            chk({tag, "_no_done"}, done, 0);
            run_cnt++;
            cyc();
        end
        hold = 1'b0;
        #1;
        chk({tag, "_run_cycles"}, run_cnt, 8 + hold_len);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_idle_part"}, part, 0);
        chk({tag, "_idle_last"}, last, 0);
        $display("txn %s order=%0d is32=%0d run_cycles=%0d", tag, order, is32v, run_cnt);
        cyc();
        chk({tag, "_done_pulse_end"}, done, 0);
    endtask

    initial begin
        logic [2:0] e;
        reset = 1'b0; in_valid = 1'b1; in_order = 2'b00; in_is32 = 1'b0;
        hold = 1'b0; flush = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_part", part, 0);
        chk("rst_first", first, 0);
        chk("rst_stall", alu_stall, 1);
        chk("rst_busy", busy_cycles, 0);
        chk("rst_is32", is32, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("idle_ready", in_ready, 1);
        $display("txn reset released");
        cyc();

        // Orders and hold
        run_instr(2'b00, 1'b0, 0, 0, "asc");
        run_instr(2'b10, 1'b1, 0, 0, "rshift");
        run_instr(2'b01, 1'b0, 0, 0, "desc");
        run_instr(2'b11, 1'b1, 0, 0, "rsvd");
        run_instr(2'b00, 1'b0, 2, 3, "hold");

        // Back-to-back with in_valid held high
        in_valid = 1'b1; in_order = 2'b00; in_is32 = 1'b0;
        #1;
        chk("b2b_accept_ready", in_ready, 1);
        for (int s = 0; s < 8; s++) exp_q.push_back(exp_part(2'b00, s));
        cyc();
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                in_order = 2'b01;
                for (int s = 0; s < 8; s++) exp_q.push_back(exp_part(2'b01, s));
            end
            if (k == 8) in_valid = 1'b0;
            #1;
            if (k == 3) chk("b2b_mid_ready", in_ready, 0);
            if (k == 7) chk("b2b_step7_ready", in_ready, 1);
            e = exp_q.pop_front();
            chk("b2b_part", part, e);
            chk("b2b_done", done, k == 8);
            chk("b2b_first", first, (k == 0) || (k == 8));
            cyc();
        end
        #1;
        chk("b2b_second_done", done, 1);
        chk("b2b_end_ready", in_ready, 1);
        $display("txn back_to_back two instructions, done at cycles 8 and 16");
        cyc();

        // Flush at step 4 while held
        in_valid = 1'b1; in_order = 2'b00;
        #1;
        for (int s = 0; s < 8; s++) exp_q.push_back(exp_part(2'b00, s));
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = exp_q.pop_front();
            chk("flush_pre_part", part, e);
            cyc();
        end
        hold = 1'b1; flush = 1'b1; in_valid = 1'b1;
        #1;
        chk("flush_ready", in_ready, 0);
        chk("flush_part", part, exp_q[0]);
        chk("flush_stall", alu_stall, 1);
        cyc();
        hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_after_done", done, 0);
        chk("flush_after_ready", in_ready, 1);
        chk("flush_after_part", part, 0);
        chk("flush_after_first", first, 0);
        chk("flush_after_stall", alu_stall, 1);
        cyc();
        chk("flush_after_done2", done, 0);
        $display("txn flush at step 4 with hold");

        // Reset at step 5
        in_valid = 1'b1; in_order = 2'b00;
        #1;
        for (int s = 0; s < 8; s++) exp_q.push_back(exp_part(2'b00, s));
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            e = exp_q.pop_front();
            chk("mrst_pre_part", part, e);
            cyc();
        end
        reset = 1'b0; in_valid = 1'b1;
        #1;
        chk("mrst_ready", in_ready, 0);
        chk("mrst_part", part, 5);
        cyc();
        reset = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("mrst_done", done, 0);
        chk("mrst_first", first, 0);
        chk("mrst_stall", alu_stall, 1);
        chk("mrst_busy", busy_cycles, 0);
        cyc();
        chk("mrst_done2", done, 0);
        $display("txn reset at step 5");
        run_instr(2'b00, 1'b0, 0, 0, "post_rst");
        chk("busy_count", busy_cycles, (PERF_ON != 0) ? 32'd8 : 32'd0);
        $display("txn busy_cycles=%0d", busy_cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
